keccak_sched: RTL and testbench

Two-requester scheduler and sequencer for the single shared SHA3-512 `keccak` core. It arbitrates whole messages between requester 0 and requester 1, and pulses the core's synchronous reset before each message. It then streams the granted requester's 32-bit words into the core under `buffer_full` back-pressure, captures the 512-bit digest and returns it tagged with the requester id.

---
 rtl/keccak_sched_if.sv | 46 ++++
 rtl/keccak_sched.sv | 162 ++++++++++++++++
 tb/tb_keccak_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_sched_if.sv
// Signal bundle between keccak_sched, its two requesters and the shared keccak core.
// master = requesters + core side, slave = the scheduler.
interface keccak_sched_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BN_W   = 2;
  localparam int unsigned DIG_W  = 512;

  logic              r0_req;
  logic              r0_valid;
  logic [WORD_W-1:0] r0_data;
  logic              r0_last;
  logic [BN_W-1:0]   r0_byte_num;
  logic              r0_ready;

  logic              r1_req;
  logic              r1_valid;
  logic [WORD_W-1:0] r1_data;
  logic              r1_last;
  logic [BN_W-1:0]   r1_byte_num;
  logic              r1_ready;

  logic              core_reset;
  logic [WORD_W-1:0] core_in;
  logic              core_in_ready;
  logic              core_is_last;
  logic [BN_W-1:0]   core_byte_num;
  logic              core_buffer_full;
  logic [DIG_W-1:0]  core_out;
  logic              core_out_ready;

  modport slave (
    input  r0_req, r0_valid, r0_data, r0_last, r0_byte_num,
    input  r1_req, r1_valid, r1_data, r1_last, r1_byte_num,
    output r0_ready, r1_ready,
    output core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
    input  core_buffer_full, core_out, core_out_ready
  );

  modport master (
    output r0_req, r0_valid, r0_data, r0_last, r0_byte_num,
    output r1_req, r1_valid, r1_data, r1_last, r1_byte_num,
    input  r0_ready, r1_ready,
    input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
    output core_buffer_full, core_out, core_out_ready
  );
endinterface

// File: rtl/keccak_sched.sv
// Two-requester message scheduler/sequencer for one shared SHA3-512 keccak core.
// Options: KECCAK_SCHED_RR_EN (round-robin arbitration), KECCAK_SCHED_WDOG_EN (WAIT watchdog + err).
module keccak_sched #(
  parameter  int unsigned TIMEOUT = 4096,
  localparam int unsigned DIG_W   = 512
) (
  input  logic             clk,
  input  logic             reset,
  keccak_sched_if.slave    bus,
  output logic [DIG_W-1:0] digest,
  output logic             digest_valid,
  output logic             digest_id,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_FEED = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   gnt_q;
  logic   gnt_d;
  logic   pick;
  logic   any_req;
  logic   g_valid;
  logic   g_last;
  logic   take;
  logic   done;
  logic   wdog_hit;

  // Granted-port word path straight into the core
  assign g_valid            = gnt_q ? bus.r1_valid : bus.r0_valid;
  assign g_last             = gnt_q ? bus.r1_last  : bus.r0_last;
  assign bus.core_in        = gnt_q ? bus.r1_data  : bus.r0_data;
  assign bus.core_is_last   = g_last;
  assign bus.core_byte_num  = gnt_q ? bus.r1_byte_num : bus.r0_byte_num;

  assign any_req = bus.r0_req || bus.r1_req;
  assign take    = (state_q == S_FEED) && g_valid && !bus.core_buffer_full;
  assign done    = (state_q == S_WAIT) && bus.core_out_ready;

`ifdef KECCAK_SCHED_RR_EN
  // prio_q=1 means requester 1 wins the next tie
  logic prio_q;

  assign pick = bus.r1_req && (!bus.r0_req || prio_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else if ((state_q == S_IDLE) && any_req) begin
      prio_q <= !pick;
    end
  end
`else
  assign pick = !bus.r0_req;
`endif

`ifdef KECCAK_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;

  // Abandon a digest that never arrives and flag it stickily
  assign wdog_hit = (state_q == S_WAIT) && !bus.core_out_ready &&
                    (wdog_q == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != S_WAIT) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + WDOG_W'(1);
      end
      if (wdog_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next state and word handshakes
  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    bus.r0_ready      = 1'b0;
    bus.r1_ready      = 1'b0;
    bus.core_in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          state_d = S_RST;
        end
      end
      S_RST: begin
        state_d = S_FEED;
      end
      S_FEED: begin
        bus.r0_ready      = !gnt_q && !bus.core_buffer_full;
        bus.r1_ready      = gnt_q && !bus.core_buffer_full;
        bus.core_in_ready = take;
        if (take && g_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done || wdog_hit) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered status, core reset pulse and digest capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_reset <= 1'b1;
      busy           <= 1'b0;
      digest         <= '0;
      digest_valid   <= 1'b0;
      digest_id      <= 1'b0;
    end else begin
      bus.core_reset <= (state_d == S_RST);
      busy           <= (state_d != S_IDLE);
      digest_valid   <= done;
      if (done) begin
        digest    <= bus.core_out;
        digest_id <= gnt_q;
      end
    end
  end

endmodule

// File: tb/tb_keccak_sched.sv
// Directed bench for keccak_sched: a toy keccak core model plus a digest scoreboard.
module tb_keccak_sched;
  localparam int unsigned LAT  = 6;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic         id;
    logic [511:0] dg;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] digest;
  logic         digest_valid;
  logic         digest_id;
  logic         busy;
  logic         err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic        bp_en;
  logic        stray;
  logic        watch_r0_quiet;
  int          core_rst_cycles = 0;
  logic [63:0] acc;
  int          fed_cnt;
  int unsigned pend;

  keccak_sched_if bus();

  keccak_sched dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_id    (digest_id),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Stand-in absorb function for the core: order, content, last and byte_num all matter
  function automatic logic [63:0] mix(input logic [63:0] a, input logic [31:0] w,
                                      input logic l, input logic [1:0] bn);
    logic [63:0] r;
    r = {a[58:0], a[63:59]} ^ {w, 29'd0, l, bn};
    return r + 64'h9E37_79B9_7F4A_7C15;
  endfunction

  function automatic logic [511:0] expand(input logic [63:0] a);
    return {4{a, ~a}};
  endfunction

  // Core model: absorbs accepted words, answers LAT cycles after the last one
  always @(posedge clk) begin
    if (bus.core_reset) begin
      acc                <= SEED;
      fed_cnt            <= 0;
      pend               <= 0;
      bus.core_out_ready <= 1'b0;
    end else begin
      bus.core_out_ready <= stray || (pend == 1);
      if (pend != 0) pend <= pend - 1;
      if (bus.core_in_ready) begin
        acc     <= mix(acc, bus.core_in, bus.core_is_last,
                       bus.core_is_last ? bus.core_byte_num : 2'd0);
        fed_cnt <= fed_cnt + 1;
        if (bus.core_is_last) pend <= LAT;
      end
    end
  end

  assign bus.core_out = expand(acc);

  always @(negedge clk) bus.core_buffer_full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Per-cycle invariants and digest scoreboard
  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (bus.core_reset) core_rst_cycles++;
      chk1("in_ready_while_full", bus.core_in_ready && bus.core_buffer_full, 1'b0);
      chk1("both_ready", bus.r0_ready && bus.r1_ready, 1'b0);
      if (watch_r0_quiet) chk1("r0_ready_quiet", bus.r0_ready, 1'b0);
      if (digest_valid) begin
        if (sb.size() == 0) begin
          chk1("unexpected_digest_valid", digest_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk1("digest_id", digest_id, e.id);
          chk("digest", digest, e.dg);
          chk1("busy_at_digest", busy, 1'b0);
        end
      end
    end
  end

  task automatic expect_msg(input logic id, input logic [31:0] w[$], input logic [1:0] bn);
    logic [63:0] a;
    a = SEED;
    for (int i = 0; i < w.size(); i++) begin
      logic l;
      l = (i == w.size() - 1);
      a = mix(a, w[i], l, l ? bn : 2'd0);
    end
    sb.push_back('{id, expand(a)});
  endtask

  task automatic drive(input logic id, input logic req, input logic valid,
                       input logic [31:0] d, input logic last, input logic [1:0] bn);
    if (id) begin
      bus.r1_req = req; bus.r1_valid = valid; bus.r1_data = d;
      bus.r1_last = last; bus.r1_byte_num = bn;
    end else begin
      bus.r0_req = req; bus.r0_valid = valid; bus.r0_data = d;
      bus.r0_last = last; bus.r0_byte_num = bn;
    end
  endtask

  task automatic send(input logic id, input logic [31:0] w[$], input logic [1:0] bn,
                      input bit drop_req, input bit chk_timing);
    int   i;
    int   cyc;
    logic rdy;
    logic req_l;
    logic is_last;
    i = 0; cyc = 0; req_l = 1'b1;
    while (i < w.size()) begin
      @(negedge clk);
      is_last = (i == w.size() - 1);
      drive(id, req_l, 1'b1, w[i], is_last, is_last ? bn : 2'd0);
      #1;
      rdy = id ? bus.r1_ready : bus.r0_ready;
      if (chk_timing && cyc == 1) begin
        chk1("rst_cycle_core_reset", bus.core_reset, 1'b1);
        chk1("rst_cycle_ready", rdy, 1'b0);
      end
      if (chk_timing && cyc == 2) begin
        chk1("feed_core_reset", bus.core_reset, 1'b0);
        chk1("feed_first_ready", rdy, 1'b1);
      end
      @(posedge clk);
      if (rdy) begin
        i++;
        if (drop_req) req_l = 1'b0;
      end
      cyc++;
      if (cyc > 600) begin
        chk("send_timeout_words", 512'(i), 512'(w.size()));
        break;
      end
    end
    @(negedge clk);
    drive(id, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pending_digests", 512'(sb.size()), 512'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] msg[$];
    logic [31:0] msga[$];
    logic [31:0] msgb[$];
    logic [31:0] msgc[$];
    int          base;
    int          n;

    reset = 1'b0; bp_en = 1'b0; stray = 1'b0; watch_r0_quiet = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);

    chk1("rst_core_reset", bus.core_reset, 1'b1);
    chk1("rst_r0_ready", bus.r0_ready, 1'b0);
    chk1("rst_r1_ready", bus.r1_ready, 1'b0);
    chk1("rst_core_in_ready", bus.core_in_ready, 1'b0);
    chk("rst_digest", digest, 512'd0);
    chk1("rst_digest_valid", digest_valid, 1'b0);
    chk1("rst_digest_id", digest_id, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);

    reset = 1'b1;
    #1 chk1("release_core_reset_held", bus.core_reset, 1'b1);
    @(posedge clk);
    #1 chk1("release_core_reset_drop", bus.core_reset, 1'b0);

    // r0 only, with latency checks on the RST/FEED entry
    base = core_rst_cycles;
    msg = {32'hA1A2A3A4, 32'h0000_0000};
    expect_msg(1'b0, msg, 2'd0);
    send(1'b0, msg, 2'd0, 1'b0, 1'b1);
    wait_drain();
    chk("t1_core_reset_pulses", 512'(core_rst_cycles - base), 512'(1));

    // r1 empty message while r0 offers an ungranted word
    watch_r0_quiet = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 2'd0);
    msg = {32'h12345678};
    expect_msg(1'b1, msg, 2'd0);
    send(1'b1, msg, 2'd0, 1'b0, 1'b0);
    wait_drain();
    watch_r0_quiet = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    chk("t2_core_reset_pulses", 512'(core_rst_cycles - base), 512'(2));

    // Back-pressure: 18 words plus the empty terminating word
    msg.delete();
    for (int i = 0; i < 18; i++) msg.push_back((i % 2 == 0) ? 32'h12345678 : 32'h90ABCDEF);
    msg.push_back(32'h0);
    expect_msg(1'b0, msg, 2'd0);
    bp_en = 1'b1;
    send(1'b0, msg, 2'd0, 1'b0, 1'b0);
    bp_en = 1'b0;
    wait_drain();
    chk("t3_words_fed", 512'(fed_cnt), 512'(19));

    // Reset in the middle of FEED aborts without a digest
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h5555AAAA, 1'b0, 2'd0);
    n = 0;
    while (fed_cnt < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("t4_feeding_before_reset", fed_cnt >= 3, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_core_reset", bus.core_reset, 1'b1);
    chk1("t4_r0_ready", bus.r0_ready, 1'b0);
    chk1("t4_core_in_ready", bus.core_in_ready, 1'b0);
    chk1("t4_digest_valid", digest_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    msg = {32'hCAFEF00D, 32'h01020300};
    expect_msg(1'b1, msg, 2'd3);
    send(1'b1, msg, 2'd3, 1'b0, 1'b0);
    wait_drain();

    // Simultaneous requests, twice; r0 requests again right after its first message
    msga = {32'h11111111, 32'h22222222};
    msgb = {32'h33333333, 32'h44444444, 32'h00000055};
    msgc = {32'h66666666};
`ifdef KECCAK_SCHED_RR_EN
    expect_msg(1'b0, msga, 2'd1);
    expect_msg(1'b1, msgb, 2'd2);
    expect_msg(1'b0, msgc, 2'd3);
`else
    expect_msg(1'b0, msga, 2'd1);
    expect_msg(1'b0, msgc, 2'd3);
    expect_msg(1'b1, msgb, 2'd2);
`endif
    fork
      begin
        send(1'b0, msga, 2'd1, 1'b0, 1'b0);
        send(1'b0, msgc, 2'd3, 1'b0, 1'b0);
      end
      send(1'b1, msgb, 2'd2, 1'b0, 1'b0);
    join
    wait_drain();

    // Stray core_out_ready in IDLE and FEED; req dropped after the first word
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (3) @(negedge clk);
    msg = {32'h0BADCAFE, 32'h10203040, 32'h50607080, 32'h90A0B000};
    expect_msg(1'b0, msg, 2'd2);
    fork
      send(1'b0, msg, 2'd2, 1'b1, 1'b0);
      begin
        repeat (4) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
      end
    join
    wait_drain();

    chk1("end_busy", busy, 1'b0);
    chk1("end_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
